// File: rtl/mvu_ctrl_pkg.sv
// rtl/mvu_ctrl_pkg.sv - shared widths, FSM states and multiply modes for the mvu job sequencer
package mvu_ctrl_pkg;

  localparam int BWBANKA = 9;
  localparam int BDBANKA = 14;
  localparam int BPREC   = 5;
  localparam int BTILE   = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MUL_OFF = 2'd0,
    MUL_BIN = 2'd1,
    MUL_TER = 2'd2,
    MUL_RSV = 2'd3
  } mul_mode_t;

endpackage

// File: rtl/mvu_ctrl_agu.sv
// rtl/mvu_ctrl_agu.sv - tile/wbit/ibit nested counters and bank address generation
module mvu_ctrl_agu
  import mvu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  input  logic               tile_inc,
  input  logic [BPREC-1:0]   iprec,
  input  logic [BPREC-1:0]   wprec,
  input  logic [BTILE-1:0]   ntiles,
  input  logic [BWBANKA-1:0] wbase,
  input  logic [BDBANKA-1:0] dbase,
  input  logic [BDBANKA-1:0] obase,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic               first_step,
  output logic               last_step,
  output logic               last_tile
);

  logic [BTILE-1:0] tile;
  logic [BPREC-1:0] wbit;
  logic [BPREC-1:0] ibit;
  logic             ibit_last;
  logic             wbit_last;

  assign ibit_last  = (ibit == iprec - BPREC'(1));
  assign wbit_last  = (wbit == wprec - BPREC'(1));
  assign first_step = (ibit == '0) && (wbit == '0);
  assign last_step  = ibit_last && wbit_last;
  assign last_tile  = (tile == ntiles - BTILE'(1));

  // ibit is the inner loop; both bit counters wrap to 0 at the end of a tile
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tile <= '0;
      wbit <= '0;
      ibit <= '0;
    end else begin
      if (step) begin
        if (ibit_last) begin
          ibit <= '0;
          wbit <= wbit_last ? '0 : wbit + BPREC'(1);
        end else begin
          ibit <= ibit + BPREC'(1);
        end
      end
      if (tile_inc) tile <= tile + BTILE'(1);
    end
  end

  assign rdw_addr = wbase + BWBANKA'(tile) * BWBANKA'(wprec) + BWBANKA'(wbit);
  assign rdd_addr = dbase + BDBANKA'(ibit);
  assign wrd_addr = obase + BDBANKA'(tile);

endmodule

// File: rtl/mvu_controller.sv
// rtl/mvu_controller.sv - mvu job sequencer (RUN/DRAIN/WRITE per tile)
// Optional max-pool controls enabled by defining MVU_CTRL_MAXPOOL_EN.
module mvu_controller
  import mvu_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         cfg_mul_mode,
  input  logic [BPREC-1:0]   cfg_iprec,
  input  logic [BPREC-1:0]   cfg_wprec,
  input  logic [BTILE-1:0]   cfg_ntiles,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_dbase,
  input  logic [BDBANKA-1:0] cfg_obase,
`ifdef MVU_CTRL_MAXPOOL_EN
  input  logic               cfg_pool,
`endif
  output logic               busy,
  output logic               done,
  output logic [1:0]         mul_mode,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               max_en,
  output logic               max_clr,
  output logic               max_pool,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t             state, state_nx;
  mul_mode_t          mode_q;
  logic [BPREC-1:0]   iprec_q, wprec_q;
  logic [BTILE-1:0]   ntiles_q;
  logic [BWBANKA-1:0] wbase_q;
  logic [BDBANKA-1:0] dbase_q, obase_q;
  logic [DW-1:0]      drain_cnt;
  logic accept, zero_job, drain_last;
  logic step, tile_inc, job_end;
  logic first_step, last_step, last_tile;

  assign accept     = (state == S_IDLE) && start && !busy;
  assign zero_job   = (cfg_iprec == '0) || (cfg_wprec == '0) || (cfg_ntiles == '0);
  assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));
  assign mul_mode   = busy ? mode_q : MUL_OFF;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdd_en   = 1'b0;
    wrd_en   = 1'b0;
    acc_clr  = 1'b0;
    acc_sh   = 1'b0;
    step     = 1'b0;
    tile_inc = 1'b0;
    job_end  = 1'b0;
    case (state)
      S_IDLE: if (accept && !zero_job) state_nx = S_RUN;
      S_RUN: begin
        rdd_en  = 1'b1;
        step    = rdd_grnt;
        acc_clr = first_step && rdd_grnt;
        acc_sh  = !first_step && rdd_grnt;
        if (rdd_grnt && last_step) state_nx = S_DRAIN;
      end
      S_DRAIN: if (drain_last) state_nx = S_WRITE;
      S_WRITE: begin
        wrd_en = 1'b1;
        if (wrd_grnt) begin
          job_end  = last_tile;
          tile_inc = !last_tile;
          state_nx = last_tile ? S_IDLE : S_RUN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A degenerate job stays in IDLE: busy is visible for one cycle alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= MUL_OFF;
      iprec_q   <= '0;
      wprec_q   <= '0;
      ntiles_q  <= '0;
      wbase_q   <= '0;
      dbase_q   <= '0;
      obase_q   <= '0;
      drain_cnt <= '0;
    end else begin
      done      <= job_end || (accept && zero_job);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
      if (accept) begin
        busy     <= 1'b1;
        mode_q   <= mul_mode_t'(cfg_mul_mode);
        iprec_q  <= cfg_iprec;
        wprec_q  <= cfg_wprec;
        ntiles_q <= cfg_ntiles;
        wbase_q  <= cfg_wbase;
        dbase_q  <= cfg_dbase;
        obase_q  <= cfg_obase;
      end else if (state == S_IDLE || job_end) begin
        busy <= 1'b0;
      end
    end
  end

  mvu_ctrl_agu u_agu (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .step       (step),
    .tile_inc   (tile_inc),
    .iprec      (iprec_q),
    .wprec      (wprec_q),
    .ntiles     (ntiles_q),
    .wbase      (wbase_q),
    .dbase      (dbase_q),
    .obase      (obase_q),
    .rdw_addr   (rdw_addr),
    .rdd_addr   (rdd_addr),
    .wrd_addr   (wrd_addr),
    .first_step (first_step),
    .last_step  (last_step),
    .last_tile  (last_tile)
  );

`ifdef MVU_CTRL_MAXPOOL_EN
  logic pool_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pool_q  <= 1'b0;
      max_clr <= 1'b1;
    end else begin
      max_clr <= accept;
      if (accept) pool_q <= cfg_pool;
    end
  end

  assign max_pool = busy && pool_q;
  assign max_en   = (state == S_DRAIN) && drain_last;
`else
  assign max_en   = 1'b0;
  assign max_clr  = 1'b1;
  assign max_pool = 1'b0;
`endif

endmodule

// File: tb/tb_mvu_controller.sv
// tb/tb_mvu_controller.sv - directed self-checking bench for mvu_controller
module tb_mvu_controller;
  import mvu_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst, start, rdd_grnt, wrd_grnt;
  logic [1:0]         cfg_mul_mode;
  logic [BPREC-1:0]   cfg_iprec, cfg_wprec;
  logic [BTILE-1:0]   cfg_ntiles;
  logic [BWBANKA-1:0] cfg_wbase;
  logic [BDBANKA-1:0] cfg_dbase, cfg_obase;
  logic               busy, done, acc_clr, acc_sh, max_en, max_clr, max_pool;
  logic               rdd_en, wrd_en;
  logic [1:0]         mul_mode;
  logic [BWBANKA-1:0] rdw_addr;
  logic [BDBANKA-1:0] rdd_addr, wrd_addr;

  int errors = 0;
  int checks = 0;
  int nrd, nwr, ndone, done_c;

  int c_rdw [6] = '{3, 3, 3, 3, 4, 4};
  int c_rdd [6] = '{7, 8, 8, 8, 7, 8};

  always #5 clk = ~clk;

  mvu_controller #(.PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_mul_mode(cfg_mul_mode), .cfg_iprec(cfg_iprec), .cfg_wprec(cfg_wprec),
    .cfg_ntiles(cfg_ntiles), .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
    .cfg_obase(cfg_obase),
    .busy(busy), .done(done), .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh),
    .max_en(max_en), .max_clr(max_clr), .max_pool(max_pool),
    .rdw_addr(rdw_addr), .rdd_en(rdd_en), .rdd_grnt(rdd_grnt), .rdd_addr(rdd_addr),
    .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int mode, input int ip, input int wp, input int nt,
                         input int wb, input int db, input int ob);
    cfg_mul_mode = 2'(mode);
    cfg_iprec    = BPREC'(ip);
    cfg_wprec    = BPREC'(wp);
    cfg_ntiles   = BTILE'(nt);
    cfg_wbase    = BWBANKA'(wb);
    cfg_dbase    = BDBANKA'(db);
    cfg_obase    = BDBANKA'(ob);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".busy"}, busy, 0);
    chk({t, ".done"}, done, 0);
    chk({t, ".acc_clr"}, acc_clr, 0);
    chk({t, ".acc_sh"}, acc_sh, 0);
    chk({t, ".rdd_en"}, rdd_en, 0);
    chk({t, ".wrd_en"}, wrd_en, 0);
    chk({t, ".rdw_addr"}, rdw_addr, 0);
    chk({t, ".rdd_addr"}, rdd_addr, 0);
    chk({t, ".wrd_addr"}, wrd_addr, 0);
    chk({t, ".mul_mode"}, mul_mode, 0);
    chk({t, ".max_en"}, max_en, 0);
    chk({t, ".max_clr"}, max_clr, 1);
    chk({t, ".max_pool"}, max_pool, 0);
  endtask

  // 2x2 bit precisions, one tile, obase 5; a stray start with new obase arrives mid-RUN.
  task automatic job_2x2(input string t);
    cyc();
    set_cfg(2, 2, 2, 1, 0, 0, 5);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      start = (c == 3);
      if (c == 3) cfg_obase = 14'd31;
      smp();
      chk($sformatf("%s.rdd_en c%0d", t, c), rdd_en, (c <= 4));
      if (c <= 4) begin
        chk($sformatf("%s.rdw_addr c%0d", t, c), rdw_addr, (c >= 3) ? 1 : 0);
        chk($sformatf("%s.rdd_addr c%0d", t, c), rdd_addr, (c == 2 || c == 4) ? 1 : 0);
      end
      chk($sformatf("%s.acc_clr c%0d", t, c), acc_clr, (c == 1));
      chk($sformatf("%s.acc_sh c%0d", t, c), acc_sh, (c >= 2 && c <= 4));
      chk($sformatf("%s.wrd_en c%0d", t, c), wrd_en, (c == 8));
      if (c == 8) chk($sformatf("%s.wrd_addr", t), wrd_addr, 5);
      chk($sformatf("%s.done c%0d", t, c), done, (c == 9));
      chk($sformatf("%s.busy c%0d", t, c), busy, (c <= 8));
      chk($sformatf("%s.mul_mode c%0d", t, c), mul_mode, (c <= 8) ? 2 : 0);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdd_grnt = 1'b1; wrd_grnt = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    smp();
    chk_reset("reset");
    cyc();
    rst = 1'b0;
    smp();

    job_2x2("A");

    // Three tiles, 1x4 precisions: weight addresses walk 10..21 linearly
    cyc();
    set_cfg(1, 1, 4, 3, 10, 100, 200);
    start = 1'b1;
    nrd = 0; nwr = 0; ndone = 0; done_c = 0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      start = 1'b0;
      smp();
      if (rdd_en) begin
        chk($sformatf("B.rdw_addr r%0d", nrd), rdw_addr, 10 + nrd);
        chk($sformatf("B.rdd_addr r%0d", nrd), rdd_addr, 100);
        nrd++;
      end
      if (wrd_en) begin
        chk($sformatf("B.wrd_addr w%0d", nwr), wrd_addr, 200 + nwr);
        nwr++;
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
    end
    chk("B.reads", nrd, 12);
    chk("B.writes", nwr, 3);
    chk("B.done_count", ndone, 1);
    chk("B.done_cycle", done_c, 25);

    // Read grant withheld in cycles 2 and 3
    cyc();
    set_cfg(1, 2, 2, 1, 3, 7, 9);
    start = 1'b1;
    nrd = 0; done_c = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      start = 1'b0;
      rdd_grnt = !(c == 2 || c == 3);
      smp();
      chk($sformatf("C.rdd_en c%0d", c), rdd_en, (c <= 6));
      if (c <= 6) begin
        chk($sformatf("C.rdw_addr c%0d", c), rdw_addr, c_rdw[c-1]);
        chk($sformatf("C.rdd_addr c%0d", c), rdd_addr, c_rdd[c-1]);
      end
      chk($sformatf("C.acc_clr c%0d", c), acc_clr, (c == 1));
      chk($sformatf("C.acc_sh c%0d", c), acc_sh, (c >= 4 && c <= 6));
      if (c == 10) chk("C.wrd_addr", wrd_addr, 9);
      chk($sformatf("C.wrd_en c%0d", c), wrd_en, (c == 10));
      if (rdd_en && rdd_grnt) nrd++;
      if (done) done_c = c;
    end
    rdd_grnt = 1'b1;
    chk("C.granted_steps", nrd, 4);
    chk("C.done_cycle", done_c, 11);

    // Write grant withheld in cycles 5..8 of a two-tile 1x1 job
    cyc();
    set_cfg(1, 1, 1, 2, 0, 0, 20);
    start = 1'b1;
    nrd = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      start = 1'b0;
      wrd_grnt = !(c >= 5 && c <= 8);
      smp();
      if (c >= 5 && c <= 9) begin
        chk($sformatf("D.wrd_en c%0d", c), wrd_en, 1);
        chk($sformatf("D.wrd_addr c%0d", c), wrd_addr, 20);
        chk($sformatf("D.rdd_en c%0d", c), rdd_en, 0);
      end
      if (c == 10) begin
        chk("D.rdd_en tile1", rdd_en, 1);
        chk("D.rdw_addr tile1", rdw_addr, 1);
      end
      if (c == 14) begin
        chk("D.wrd_en tile1", wrd_en, 1);
        chk("D.wrd_addr tile1", wrd_addr, 21);
      end
      chk($sformatf("D.done c%0d", c), done, (c == 15));
      if (rdd_en) nrd++;
    end
    wrd_grnt = 1'b1;
    chk("D.reads", nrd, 2);

    // Reset in the middle of DRAIN aborts with no write, then a fresh job runs cleanly
    cyc();
    set_cfg(2, 2, 2, 1, 0, 0, 5);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      start = 1'b0;
      rst = (c == 6);
    end
    cyc();
    rst = 1'b0;
    smp();
    chk_reset("E.abort");
    for (int c = 8; c <= 14; c++) begin
      cyc();
      smp();
      chk($sformatf("E.wrd_en c%0d", c), wrd_en, 0);
      chk($sformatf("E.done c%0d", c), done, 0);
      chk($sformatf("E.busy c%0d", c), busy, 0);
    end
    job_2x2("E.rerun");

    // Zero weight precision: done next cycle, no traffic; start while busy is ignored
    cyc();
    set_cfg(1, 2, 0, 1, 0, 0, 0);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      start = (c == 1);
      if (c == 1) cfg_wprec = 5'd1;
      smp();
      chk($sformatf("F.done c%0d", c), done, (c == 1));
      chk($sformatf("F.busy c%0d", c), busy, (c == 1));
      chk($sformatf("F.rdd_en c%0d", c), rdd_en, 0);
      chk($sformatf("F.wrd_en c%0d", c), wrd_en, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvu_controller.md
Name: mvu_controller

Overview:
Job sequencer for one mvu instance. It accepts a bit-serial matrix-vector job (precisions, tile count, base addresses) and steps the MVU's weight/data read addresses and accumulator controls through every bit-pair of every output tile. After each tile it waits out the datapath latency, then issues the result write-back. It sits between the host/command layer and the mvu control ports; one instance per MVU.

Parameters:
N, 64, MVU vector size; informational, no width dependence here
BWBANKA, 9, weight bank address width
BDBANKA, 14, data bank address width
BPREC, 5, precision field width (values 0..16 used)
BTILE, 9, tile count width
PIPE_LAT, 3, cycles from last accumulate step to result valid at write port (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request; sampled only in IDLE
cfg_mul_mode  in  2  multiply mode for job
cfg_iprec  in  BPREC  input bit precision
cfg_wprec  in  BPREC  weight bit precision
cfg_ntiles  in  BTILE  output tiles in job
cfg_wbase  in  BWBANKA  weight base address
cfg_dbase  in  BDBANKA  input data base address
cfg_obase  in  BDBANKA  output base address
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
mul_mode  out  2  to mvu
acc_clr  out  1  to mvu
acc_sh  out  1  to mvu
max_en  out  1  to mvu
max_clr  out  1  to mvu
max_pool  out  1  to mvu
rdw_addr  out  BWBANKA  to mvu
rdd_en  out  1  to mvu
rdd_grnt  in  1  from mvu
rdd_addr  out  BDBANKA  to mvu
wrd_en  out  1  to mvu
wrd_grnt  in  1  from mvu
wrd_addr  out  BDBANKA  to mvu

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, done=0, acc_clr=0, acc_sh=0, rdd_en=0, wrd_en=0, all addresses 0, mul_mode=0, max_en=0, max_clr=1, max_pool=0. Reset mid-job aborts immediately, with no write.
- States: IDLE, RUN, DRAIN, WRITE.
- IDLE: start=1 latches all cfg_* and sets busy=1. If any of iprec/wprec/ntiles is 0, the next cycle pulses done and stays IDLE, with no reads or writes. Otherwise go to RUN. start while busy is ignored.
- RUN: counters tile, wbit (outer), ibit (inner), all from 0. Each cycle: rdd_en=1; rdw_addr=wbase+tile*wprec+wbit; rdd_addr=dbase+ibit.
- acc_clr=1 on the first step of a tile; acc_sh=1 on every other step. Both are combinationally ANDed with rdd_grnt.
- A step advances only when rdd_grnt=1. Otherwise the addresses hold and the step repeats.
- After iprec*wprec granted steps, go to DRAIN with rdd_en=0.
- DRAIN: hold for exactly PIPE_LAT cycles, then go to WRITE.
- WRITE: wrd_en=1, wrd_addr=obase+tile. Hold until wrd_grnt=1.
- On the grant: if tile==ntiles-1, pulse done, drop busy and go to IDLE. Otherwise increment tile and go to RUN.
- Address arithmetic wraps modulo 2^width. mul_mode is driven from the latched value while busy and is 0 in IDLE.
- Cycle count, no stalls: start accepted at edge 0; RUN occupies cycles 1..iprec*wprec; DRAIN follows; WRITE lasts 1 cycle; done is asserted in the cycle after the final WRITE grant.

Optional Feature:
MVU_CTRL_MAXPOOL_EN.
- Defined: adds input port cfg_pool (1 bit), latched on start. max_pool equals the latched cfg_pool while busy. max_clr pulses for 1 cycle on job start. max_en=1 during the last DRAIN cycle of every tile.
- Undefined: cfg_pool is absent; max_en=0, max_clr=1, max_pool=0 constantly.

Decomposition:
- Package mvu_ctrl_pkg holds:
  - BWBANKA, BDBANKA, BPREC and BTILE constants.
  - State enum.
  - mul_mode enum (0 off, 1 binary {0,+1}, 2 ternary, 3 reserved).
- Sub-module mvu_ctrl_agu: tile/wbit/ibit nested counters with step-enable, last-flags and address adders. The FSM stays in mvu_controller.

Test Plan:
- iprec=2, wprec=2, ntiles=1, wbase=0, dbase=0, obase=5, PIPE_LAT=3, grants tied 1:
  - rdw_addr sequence 0,0,1,1; rdd_addr sequence 0,1,0,1.
  - acc_clr in cycle 1 only; acc_sh in cycles 2-4.
  - wrd_en at cycle 8 with addr 5; done at cycle 9.
- ntiles=3, iprec=1, wprec=4, wbase=10: rdw_addr spans 10..21; writes go to obase+0..2; exactly 3 wrd_en grants, then one done pulse.
- Drop rdd_grnt for 2 cycles mid-RUN: address held, acc_sh low on those cycles, total granted steps still iprec*wprec.
- Hold wrd_grnt=0 for 4 cycles: wrd_en and wrd_addr held stable; no next-tile reads until the grant.
- Assert rst during DRAIN: next cycle all outputs at reset values, no write; then start a new job and check that it runs normally.
- cfg_wprec=0 with start: done pulses next cycle, rdd_en/wrd_en never asserted; start pulses while busy have no effect.
